morse_encoder: RTL and testbench

Character-serial Morse transmitter: the outbound counterpart of the button-driven Morse decoder path. Accepts 8-bit ASCII characters over a valid/ready handshake, looks each one up in a Morse code table, and drives a keyed output (LED/buzzer) with standard unit timing: dot, dash, intra-character gap, letter gap and word gap. Sits between a character source (FIFO or UART) and a board output pin. Uses the same `{len[2:0], pattern[4:0]}` code format as the decoder, with 1 = dash and the first symbol in bit `len-1`.

---
 rtl/morse_pkg.sv | 25 ++
 rtl/ascii2morse_rom.sv | 65 ++++++
 rtl/morse_encoder.sv | 189 ++++++++++++++++++
 tb/tb_morse_encoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse state, code-format and timing constants.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MARK  = 3'd2,
    SPACE = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int LEN_W = 3;
  localparam int PAT_W = 5;

  localparam int DASH_UNITS           = 3;
  localparam int LETTER_GAP_UNITS     = 3;
  localparam int WORD_GAP_EXTRA_UNITS = 4;

  localparam logic [LEN_W+PAT_W-1:0] WORD_GAP_CODE = 8'b1110_0000;

  function automatic logic [7:0] fold_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

endpackage

// File: rtl/ascii2morse_rom.sv
// rtl/ascii2morse_rom.sv - 256x8 synchronous ASCII to {len, pattern} ROM.
// Pattern: 1 = dash, first symbol in bit len-1; unsupported codes read 8'h00.
module ascii2morse_rom
  import morse_pkg::*;
(
  input  logic                   clk,
  input  logic                   en,
  input  logic [7:0]             addr,
  output logic [LEN_W+PAT_W-1:0] data
);

  logic [LEN_W+PAT_W-1:0] data_d;
  logic [LEN_W+PAT_W-1:0] data_q;

  always_comb begin
    data_d = 8'h00;
    case (addr)
      8'h20: data_d = WORD_GAP_CODE;
      8'h30: data_d = {3'd5, 5'b11111};
      8'h31: data_d = {3'd5, 5'b01111};
      8'h32: data_d = {3'd5, 5'b00111};
      8'h33: data_d = {3'd5, 5'b00011};
      8'h34: data_d = {3'd5, 5'b00001};
      8'h35: data_d = {3'd5, 5'b00000};
      8'h36: data_d = {3'd5, 5'b10000};
      8'h37: data_d = {3'd5, 5'b11000};
      8'h38: data_d = {3'd5, 5'b11100};
      8'h39: data_d = {3'd5, 5'b11110};
      8'h41: data_d = {3'd2, 5'b00001};
      8'h42: data_d = {3'd4, 5'b01000};
      8'h43: data_d = {3'd4, 5'b01010};
      8'h44: data_d = {3'd3, 5'b00100};
      8'h45: data_d = {3'd1, 5'b00000};
      8'h46: data_d = {3'd4, 5'b00010};
      8'h47: data_d = {3'd3, 5'b00110};
      8'h48: data_d = {3'd4, 5'b00000};
      8'h49: data_d = {3'd2, 5'b00000};
      8'h4A: data_d = {3'd4, 5'b00111};
      8'h4B: data_d = {3'd3, 5'b00101};
      8'h4C: data_d = {3'd4, 5'b00100};
      8'h4D: data_d = {3'd2, 5'b00011};
      8'h4E: data_d = {3'd2, 5'b00010};
      8'h4F: data_d = {3'd3, 5'b00111};
      8'h50: data_d = {3'd4, 5'b00110};
      8'h51: data_d = {3'd4, 5'b01101};
      8'h52: data_d = {3'd3, 5'b00010};
      8'h53: data_d = {3'd3, 5'b00000};
      8'h54: data_d = {3'd1, 5'b00001};
      8'h55: data_d = {3'd3, 5'b00001};
      8'h56: data_d = {3'd4, 5'b00001};
      8'h57: data_d = {3'd3, 5'b00011};
      8'h58: data_d = {3'd4, 5'b01001};
      8'h59: data_d = {3'd4, 5'b01011};
      8'h5A: data_d = {3'd4, 5'b01100};
      default: data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (en) data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - character-serial Morse keyer with unit timing.
// MORSE_TONE_EN adds a square-wave tone gated by key; otherwise tone is 0.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int TIMER_FINAL_VALUE = 9_999_999,
  parameter int TONE_DIV          = 24_999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key,
  output logic       tone,
  output logic       busy,
  output logic       err
);

  localparam int TW = (TIMER_FINAL_VALUE > 0) ? $clog2(TIMER_FINAL_VALUE + 1) : 1;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [1:0]             unit_q, unit_d;
  logic [2:0]             gap_cnt_q, gap_cnt_d;
  logic [2:0]             gap_len_q, gap_len_d;
  logic [2:0]             idx_q, idx_d;
  logic                   key_q, key_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic [LEN_W+PAT_W-1:0] code;
  logic [LEN_W-1:0]       code_len;
  logic [PAT_W-1:0]       code_pat;
  logic                   accept;
  logic                   tick;
  logic                   is_dash;

  assign accept   = in_valid & ready_q;
  assign code_len = code[LEN_W+PAT_W-1:PAT_W];
  assign code_pat = code[PAT_W-1:0];
  assign tick     = (timer_q == TW'(TIMER_FINAL_VALUE));
  assign is_dash  = code_pat[idx_q];

  // The ROM register doubles as the accepted-character register.
  ascii2morse_rom u_rom (
    .clk  (clk),
    .en   (accept),
    .addr (fold_upper(in_data)),
    .data (code)
  );

  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    gap_cnt_d = gap_cnt_q;
    gap_len_d = gap_len_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    timer_d   = tick ? '0 : timer_q + 1'b1;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        timer_d   = '0;
        unit_d    = '0;
        gap_cnt_d = '0;
        if (code_len == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (code == WORD_GAP_CODE) begin
          gap_len_d = 3'(WORD_GAP_EXTRA_UNITS);
          state_d   = GAP;
        end else begin
          idx_d   = code_len - 1'b1;
          state_d = MARK;
        end
      end
      MARK: begin
        if (tick) begin
          if (unit_q == (is_dash ? 2'(DASH_UNITS - 1) : 2'd0)) begin
            unit_d = '0;
            if (idx_q == '0) begin
              gap_len_d = 3'(LETTER_GAP_UNITS);
              gap_cnt_d = '0;
              state_d   = GAP;
            end else begin
              state_d = SPACE;
            end
          end else begin
            unit_d = unit_q + 1'b1;
          end
        end
      end
      SPACE: begin
        if (tick) begin
          idx_d   = idx_q - 1'b1;
          state_d = MARK;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q == gap_len_q - 1'b1) begin
            gap_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Every element starts on a fresh unit boundary.
    if (state_d != state_q) timer_d = '0;
    key_d   = (state_d == MARK);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      unit_q    <= '0;
      gap_cnt_q <= '0;
      gap_len_q <= '0;
      idx_q     <= '0;
      key_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      unit_q    <= unit_d;
      gap_cnt_q <= gap_cnt_d;
      gap_len_q <= gap_len_d;
      idx_q     <= idx_d;
      key_q     <= key_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign key      = key_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign in_ready = ready_q;

`ifdef MORSE_TONE_EN
  localparam int DW = (TONE_DIV > 0) ? $clog2(TONE_DIV + 1) : 1;

  logic [DW-1:0] tone_cnt_q, tone_cnt_d;
  logic          sq_q, sq_d;

  // Held in reset while unkeyed so each mark starts with the same phase.
  always_comb begin
    tone_cnt_d = tone_cnt_q + 1'b1;
    sq_d       = sq_q;
    if (!key_q) begin
      tone_cnt_d = '0;
      sq_d       = 1'b0;
    end else if (tone_cnt_q == DW'(TONE_DIV)) begin
      tone_cnt_d = '0;
      sq_d       = ~sq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tone_cnt_q <= '0;
      sq_q       <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      sq_q       <= sq_d;
    end
  end

  assign tone = key_q & sq_q;
`else
  logic unused_tone_div;
  assign unused_tone_div = ^TONE_DIV;
  assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - self-checking bench for morse_encoder with U=4.
module tb_morse_encoder;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, key, tone, busy, err;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits [10] = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};
  string pool = "ETAINOSHRDLUaeiouz0123456789Q @#.?";

  always #5 clk = ~clk;

  morse_encoder #(
    .TIMER_FINAL_VALUE (3),
    .TONE_DIV          (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key      (key),
    .tone     (tone),
    .busy     (busy),
    .err      (err)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_tone(input string tag);
`ifdef MORSE_TONE_EN
    check({tag, " tone_gate"}, tone & ~key, 1'b0);
`else
    check({tag, " tone"}, tone, 1'b0);
`endif
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, " ready_wait"}, in_ready, 1'b1);
  endtask

  // Expected key per cycle after the accept edge, built from dot/dash strings.
  task automatic send(input logic [7:0] c, input bit hold, input string name);
    logic [7:0] uc;
    string      m;
    bit         sup;
    uc  = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    sup = 1'b1;
    m   = "";
    exp_q = {};
    exp_q.push_back(1'b0);
    if (uc == 8'h20) begin
      repeat (4 * U) exp_q.push_back(1'b0);
    end else begin
      if (uc >= 8'h41 && uc <= 8'h5A) m = letters[uc - 8'h41];
      else if (uc >= 8'h30 && uc <= 8'h39) m = digits[uc - 8'h30];
      else sup = 1'b0;
      if (sup) begin
        for (int i = 0; i < m.len(); i++) begin
          if (i > 0) repeat (U) exp_q.push_back(1'b0);
          repeat ((m[i] == 8'h2D) ? 3 * U : U) exp_q.push_back(1'b1);
        end
        repeat (3 * U) exp_q.push_back(1'b0);
      end
    end
    wait_ready(name);
    in_data  = c;
    in_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0 && !hold) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      check({name, " key"}, key, exp_q[k]);
      check({name, " busy"}, busy, 1'b1);
      check({name, " in_ready"}, in_ready, 1'b0);
      check({name, " err"}, err, 1'b0);
      check_tone(name);
    end
    @(negedge clk);
    check({name, " end in_ready"}, in_ready, 1'b1);
    check({name, " end busy"}, busy, 1'b0);
    check({name, " end key"}, key, 1'b0);
    check({name, " end err"}, err, !sup);
  endtask

  initial begin
    logic [7:0] c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset key", key, 1'b0);
    check("reset tone", tone, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset err", err, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    send(8'h45, 1'b0, "E");
    send(8'h61, 1'b0, "a");
    send(8'h30, 1'b0, "0");
    send(8'h54, 1'b1, "T_held");
    send(8'h20, 1'b0, "space");
    send(8'h23, 1'b0, "hash");

    // Reset in the middle of the dash of 'T'.
    wait_ready("rst_T");
    in_data  = 8'h54;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_T mid key", key, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst key", key, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst err", err, 1'b0);
    send(8'h45, 1'b0, "E_after_rst");

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) c = 8'($urandom_range(0, 255));
      else c = pool[$urandom_range(0, pool.len() - 1)];
      send(c, 1'b0, $sformatf("rnd%0d_%02h", n, c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
